// File: rtl/uart_wrapper_if.sv
// uart_wrapper_if: host-side serial lines and command/response handshake of uart_wrapper.
interface uart_wrapper_if;
    logic        RX;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;
    modport slave (input RX, clr_cmd_rdy, send_resp, resp, output TX, cmd, data, cmd_rdy, resp_sent);
    modport master(output RX, clr_cmd_rdy, send_resp, resp, input TX, cmd, data, cmd_rdy, resp_sent);
endinterface

// File: rtl/uart_wrapper.sv
// uart_wrapper: 8N1 UART that assembles 3-byte command frames and transmits 1-byte responses.
module uart_wrapper #(
    parameter int BAUD_CNT = 2604,
    parameter int BYTE_TMO = 1 << 20
) (
    input logic clk,
    input logic rst_n,
    uart_wrapper_if.slave u
);
    localparam int BW = $clog2(BAUD_CNT + 1);
    localparam int TW = $clog2(BYTE_TMO + 1);
    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
    state_t st, nx;
    logic [2:0] rx_sync;
    logic rx_s, rx_prev, rx_busy, rx_tick, byte_v, fr_err, tmo;
    logic [BW-1:0] rx_cnt, tx_cnt;
    logic [3:0] rx_idx, tx_idx;
    logic [7:0] rx_sh;
    logic [TW-1:0] tmo_cnt;
    logic ld_cmd, ld_hi, ld_lo, set_rdy, tx_busy;
    logic [9:0] tx_sh;
    // [1:0] is the two-flop synchronizer, [2] holds the previous value for falling-edge start detection
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rx_sync <= 3'b111;
        else rx_sync <= {rx_sync[1:0], u.RX};
    assign rx_s    = rx_sync[1];
    assign rx_prev = rx_sync[2];
    assign rx_tick = rx_busy && rx_cnt == '0;
    assign byte_v  = rx_tick && rx_idx == 4'd9 && rx_s;
    assign fr_err  = rx_tick && rx_idx == 4'd9 && !rx_s;
    // rx_idx: 0 start bit, 1..8 data bits, 9 stop bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_idx  <= '0;
            rx_sh   <= '0;
        end else if (!rx_busy) begin
            if (rx_prev && !rx_s) begin
                rx_busy <= 1'b1;
                rx_cnt  <= BW'(BAUD_CNT / 2 - 1);
                rx_idx  <= '0;
            end
        end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
        end else begin
            rx_cnt <= BW'(BAUD_CNT - 1);
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx inside {[4'd1:4'd8]}) rx_sh <= {rx_s, rx_sh[7:1]};
            if ((rx_idx == 4'd0 && rx_s) || rx_idx == 4'd9) rx_busy <= 1'b0;
        end
    assign tmo = st != IDLE && tmo_cnt == TW'(BYTE_TMO - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else st <= nx;
    always_comb
        nx = (fr_err || tmo) ? IDLE :
             !byte_v         ? st :
             st == IDLE      ? WAIT_HI :
             st == WAIT_HI   ? WAIT_LO : IDLE;
    always_comb begin
        ld_cmd = byte_v && st == IDLE;
        ld_hi  = byte_v && st == WAIT_HI;
        ld_lo  = byte_v && st == WAIT_LO;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            u.cmd     <= '0;
            u.data    <= '0;
            u.cmd_rdy <= 1'b0;
            set_rdy   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            tmo_cnt <= (st == IDLE || byte_v) ? '0 : tmo_cnt + 1'b1;
            set_rdy <= ld_lo;
            if (ld_cmd) u.cmd <= rx_sh;
            if (ld_hi) u.data[15:8] <= rx_sh;
            if (ld_lo) u.data[7:0] <= rx_sh;
            if (set_rdy) u.cmd_rdy <= 1'b1;
            else if (u.clr_cmd_rdy || ld_cmd) u.cmd_rdy <= 1'b0;
        end
    // tx_sh[0] drives the line; it reads 1 when idle because the stop bit and shifted-in ones remain
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (u.send_resp) begin
                tx_busy <= 1'b1;
                tx_sh   <= {1'b1, u.resp, 1'b0};
                tx_cnt  <= BW'(BAUD_CNT - 1);
                tx_idx  <= '0;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
        end else if (tx_idx == 4'd9) begin
            tx_busy <= 1'b0;
        end else begin
            tx_idx <= tx_idx + 4'd1;
            tx_sh  <= {1'b1, tx_sh[9:1]};
            tx_cnt <= BW'(BAUD_CNT - 1);
        end
    assign u.TX        = tx_sh[0];
    assign u.resp_sent = tx_busy && tx_cnt == '0 && tx_idx == 4'd9;
endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 Parameter BAUD_CNT, default 2604, clocks per UART bit (19200 baud at 50 MHz).
REQ-002 Parameter BYTE_TMO, default 2^20, max clocks between bytes of one command frame.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 RX  in  1  serial line from host, idle high, asynchronous to clk.
REQ-007 TX  out  1  serial line to host, idle high.
REQ-008 cmd  out  8  opcode byte of last complete frame.
REQ-009 data  out  16  payload of last complete frame.
REQ-010 cmd_rdy  out  1  complete frame held on cmd/data.
REQ-011 clr_cmd_rdy  in  1  consumer acknowledge, clears cmd_rdy.
REQ-012 send_resp  in  1  one-cycle strobe, transmit resp.
REQ-013 resp  in  8  response byte (0xA5 = ack).
REQ-014 resp_sent  out  1  one-cycle pulse when the resp stop bit completes.

Function
REQ-015 Serial format SHALL be 8N1, LSB first; each bit lasts BAUD_CNT clocks.
REQ-016 RX SHALL pass through a two-flop synchronizer preset to 1 before any use.
REQ-017 Receiver start: synchronized RX low while idle; first sample at BAUD_CNT/2, then every BAUD_CNT clocks.
REQ-018 Receiver: start bit read high at mid-bit -> glitch, return idle, no byte.
REQ-019 Receiver: stop bit read low -> framing error, byte discarded, frame FSM to IDLE.
REQ-020 Frame FSM states: IDLE, WAIT_HI, WAIT_LO.
REQ-021 IDLE + byte: latch into cmd, go WAIT_HI.
REQ-022 WAIT_HI + byte: latch into data[15:8], go WAIT_LO.
REQ-023 WAIT_LO + byte: latch into data[7:0], set cmd_rdy the cycle after, go IDLE.
REQ-024 cmd/data SHALL change only on byte latch; they hold while cmd_rdy=1 until a new frame begins.
REQ-025 cmd_rdy SHALL clear on clr_cmd_rdy or on latching a new cmd byte; if set and clear coincide, set wins.
REQ-026 In WAIT_HI/WAIT_LO, BYTE_TMO clocks without a byte -> IDLE, partial frame dropped, cmd_rdy unchanged.
REQ-027 Transmitter: send_resp while idle latches resp, drives start bit next cycle, then 8 data bits and 1 stop bit.
REQ-028 send_resp while transmitting SHALL be ignored; resp changes mid-byte do not affect TX.
REQ-029 resp_sent SHALL pulse exactly once, on the clock ending the stop bit; a new byte may start the next cycle.
REQ-030 Receiver and transmitter SHALL run concurrently and independently (full duplex).
REQ-031 Baud and timeout counters SHALL be sized for their parameters and never wrap mid-bit.

Reset
REQ-032 On rst_n low: TX=1, cmd_rdy=0, resp_sent=0, cmd=0, data=0, FSM=IDLE, receiver/transmitter idle, synchronizer=1.
REQ-033 Reset mid-byte or mid-frame SHALL drop all partial state; after release, the first falling RX edge starts a new byte.

Verification
REQ-034 Send 0x02,0x12,0x34 at BAUD_CNT -> cmd=0x02, data=0x1234, cmd_rdy=1 within 2 clocks of third stop-bit sample.
REQ-035 Hold cmd_rdy, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle; cmd/data unchanged.
REQ-036 Send 0x05,0x01 then idle BYTE_TMO+10 clocks, then 0x06,0x00,0x00 -> only cmd=0x06, data=0x0000 reported.
REQ-037 resp=0xA5, pulse send_resp -> TX shows 0,1,0,1,0,0,1,0,1,1 for BAUD_CNT clocks each; resp_sent pulses once at 10*BAUD_CNT.
REQ-038 RX low pulse of BAUD_CNT/4 -> no byte and FSM stays IDLE; byte with stop bit low -> discarded, cmd_rdy=0.
REQ-039 Assert rst_n low mid-second byte -> all outputs at reset values; next full frame 0x08,0xFF,0xFF decodes correctly.
